// File: rtl/memctl_pkg.sv
// memctl_pkg -- shared definitions for the memctl block.
//   state_e      : controller FSM states (IDLE, BUSY, RESP)
//   WT_*         : store size codes carried on writetype
//   LAT_DEFAULT  : default number of BUSY cycles per access
package memctl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [1:0] WT_BYTE  = 2'b00;
    localparam logic [1:0] WT_WORD  = 2'b01;
    localparam logic [1:0] WT_DWORD = 2'b10;

    localparam int LAT_DEFAULT = 2;

endpackage

// File: rtl/memctl_merge.sv
// memmerge -- combinational store lane merge.
//   old_dw    in  : current doubleword from storage
//   wdata     in  : store data, right-justified
//   adr_lo    in  : adr[2:0] of the store
//   writetype in  : WT_BYTE / WT_WORD / WT_DWORD
//   merged    out : doubleword with the selected lanes replaced
// Byte lanes are big-endian inside each 32-bit word: adr[1:0]=0 is the
// most significant byte of the word, adr[2] selects the word half.
module memmerge
    import memctl_pkg::*;
#(
    parameter int N = 64
) (
    input  logic [N-1:0] old_dw,
    input  logic [N-1:0] wdata,
    input  logic [2:0]   adr_lo,
    input  logic [1:0]   writetype,
    output logic [N-1:0] merged
);

    localparam int LANES = N / 8;

    // Physical lane index of the addressed byte.
    logic [2:0] byte_lane;
    assign byte_lane = {adr_lo[2], ~adr_lo[1:0]};

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            localparam logic [2:0] LANE = 3'(gi);
            logic byte_hit;
            logic word_hit;
            logic dw_hit;

            assign byte_hit = (writetype == WT_BYTE)  && (byte_lane == LANE);
            assign word_hit = (writetype == WT_WORD)  && (adr_lo[2] == LANE[2]);
            assign dw_hit   = (writetype == WT_DWORD);

            always_comb begin
                merged[8*gi +: 8] = old_dw[8*gi +: 8];
                if (byte_hit)
                    merged[8*gi +: 8] = wdata[7:0];
                else if (word_hit)
                    merged[8*gi +: 8] = wdata[8*(gi%4) +: 8];
                else if (dw_hit)
                    merged[8*gi +: 8] = wdata[8*gi +: 8];
            end
        end
    endgenerate

endmodule

// File: rtl/memctl.sv
// memctl -- single-port doubleword memory controller with fixed latency.
//   clk       in  : clock, all state on rising edge
//   reset     in  : synchronous active-high reset (storage is kept)
//   req       in  : access request, taken only in IDLE
//   we        in  : 1 store, 0 load
//   writetype in  : store size (byte / word / doubleword, 11 reserved)
//   adr       in  : byte address
//   writedata in  : store data, right-justified
//   ready     out : one-cycle completion pulse
//   readdata  out : load response, held between loads
//   misalign  out : error flag, valid with ready
module memctl
    import memctl_pkg::*;
#(
    parameter int N     = 64,
    parameter int DEPTH = 256,
    parameter int LAT   = LAT_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req,
    input  logic         we,
    input  logic [1:0]   writetype,
    input  logic [N-1:0] adr,
    input  logic [N-1:0] writedata,
    output logic         ready,
    output logic [N-1:0] readdata,
    output logic         misalign
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LAT + 1);
    localparam int H  = N / 2;

    state_e          state_reg;
    logic [CW-1:0]   cnt_reg;
    logic            we_reg;
    logic [1:0]      wt_reg;
    logic [AW+2:0]   adr_reg;
    logic [N-1:0]    wdata_reg;
    logic [N-1:0]    rd_reg;
    logic [N-1:0]    readdata_reg;
    logic            ready_reg;
    logic            misalign_reg;
    logic [N-1:0]    merged;
    logic            mis_next;
    logic            last_busy;
    logic            commit;

    logic [N-1:0]    mem [DEPTH];

    // Address bits above the storage index wrap around.
    logic unused_adr_hi;
    assign unused_adr_hi = ^adr[N-1:AW+3];

    // Only stores can be misaligned; loads ignore writetype.
    always_comb begin
        mis_next = 1'b0;
        if (we_reg) begin
            if (wt_reg == WT_WORD && adr_reg[1:0] != 2'b00)
                mis_next = 1'b1;
            else if (wt_reg == WT_DWORD && adr_reg[2:0] != 3'b000)
                mis_next = 1'b1;
            else if (wt_reg == 2'b11)
                mis_next = 1'b1;
        end
    end

    assign last_busy = (state_reg == BUSY) && (cnt_reg == '0);
    // Reset on the commit edge aborts the store.
    assign commit    = last_busy && we_reg && !mis_next && !reset;

    memmerge #(.N(N)) u_merge (
        .old_dw    (rd_reg),
        .wdata     (wdata_reg),
        .adr_lo    (adr_reg[2:0]),
        .writetype (wt_reg),
        .merged    (merged)
    );

    // Storage with registered read. The read is issued while IDLE so the
    // addressed doubleword is in rd_reg for the whole BUSY phase; nothing
    // else writes storage meanwhile, so it stays valid until commit.
    always_ff @(posedge clk) begin
        if (commit)
            mem[adr_reg[AW+2:3]] <= merged;
        if (state_reg == IDLE)
            rd_reg <= mem[adr[AW+2:3]];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            ready_reg    <= 1'b0;
            misalign_reg <= 1'b0;
            readdata_reg <= '0;
        end else begin
            ready_reg    <= 1'b0;
            misalign_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req) begin
                        we_reg    <= we;
                        wt_reg    <= writetype;
                        adr_reg   <= adr[AW+2:0];
                        wdata_reg <= writedata;
                        cnt_reg   <= CW'(LAT - 1);
                        state_reg <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_reg == '0) begin
                        state_reg <= RESP;
                        // Addressed word lands in the low half.
                        if (!we_reg)
                            readdata_reg <= adr_reg[2] ? {rd_reg[H-1:0], rd_reg[N-1:H]}
                                                       : rd_reg;
                    end else begin
                        cnt_reg <= cnt_reg - CW'(1);
                    end
                end
                RESP: begin
                    // Registered pulse: visible in the cycle after RESP.
                    ready_reg    <= 1'b1;
                    misalign_reg <= mis_next;
                    state_reg    <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign ready    = ready_reg;
    assign readdata = readdata_reg;
    assign misalign = misalign_reg;

endmodule

// File: tb/tb_memctl.sv
module tb_memctl;

    localparam int N     = 64;
    localparam int DEPTH = 256;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req = 1'b0;
    logic         we = 1'b0;
    logic [1:0]   writetype = 2'b00;
    logic [N-1:0] adr = '0;
    logic [N-1:0] writedata = '0;
    logic         ready;
    logic [N-1:0] readdata;
    logic         misalign;

    int pass_cnt  = 0;
    int total_cnt = 0;

    memctl #(.N(N), .DEPTH(DEPTH), .LAT(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .writetype (writetype),
        .adr       (adr),
        .writedata (writedata),
        .ready     (ready),
        .readdata  (readdata),
        .misalign  (misalign)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One access; reports cycles from accept edge to ready (-1 = none).
    task automatic run(input logic w, input logic [1:0] wt, input logic [N-1:0] a,
                       input logic [N-1:0] wd, output int cyc, output logic mis,
                       output logic [N-1:0] rd);
        bit found;
        @(negedge clk);
        req = 1'b1; we = w; writetype = wt; adr = a; writedata = wd;
        @(posedge clk);
        #1 req = 1'b0;
        cyc = -1; mis = 1'bx; rd = 'x; found = 0;
        for (int k = 1; k <= 10 && !found; k++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                found = 1; cyc = k; mis = misalign; rd = readdata;
            end
        end
        $display("txn we=%0b wt=%0d adr=%h wd=%h -> cyc=%0d mis=%0b rd=%h",
                 w, wt, a, wd, cyc, mis, rd);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++; if (ready !== 1'b0) $display("FAIL reset_ready got=%b exp=0", ready); else pass_cnt++;
        total_cnt++; if (misalign !== 1'b0) $display("FAIL reset_mis got=%b exp=0", misalign); else pass_cnt++;
        total_cnt++; if (readdata !== 64'h0) $display("FAIL reset_rd got=%h exp=0", readdata); else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_dword();
        int c; logic m; logic [N-1:0] r;
        run(1'b1, 2'b10, 64'h10, 64'h1122334455667788, c, m, r);
        total_cnt++; if (c !== 3) $display("FAIL dw_store_lat got=%0d exp=3", c); else pass_cnt++;
        total_cnt++; if (m !== 1'b0) $display("FAIL dw_store_mis got=%b exp=0", m); else pass_cnt++;
        total_cnt++; if (r !== 64'h0) $display("FAIL dw_store_rd_kept got=%h exp=0", r); else pass_cnt++;
        run(1'b0, 2'b00, 64'h10, 64'h0, c, m, r);
        total_cnt++; if (r !== 64'h1122334455667788) $display("FAIL dw_load10 got=%h exp=1122334455667788", r); else pass_cnt++;
        total_cnt++; if (m !== 1'b0) $display("FAIL dw_load_mis got=%b exp=0", m); else pass_cnt++;
        run(1'b0, 2'b00, 64'h14, 64'h0, c, m, r);
        total_cnt++; if (r !== 64'h5566778811223344) $display("FAIL dw_load14 got=%h exp=5566778811223344", r); else pass_cnt++;
    endtask

    task automatic test_byte();
        int c; logic m; logic [N-1:0] r;
        run(1'b1, 2'b00, 64'h11, 64'hAB, c, m, r);
        total_cnt++; if (m !== 1'b0) $display("FAIL byte_store_mis got=%b exp=0", m); else pass_cnt++;
        run(1'b0, 2'b00, 64'h10, 64'h0, c, m, r);
        total_cnt++; if (r !== 64'h1122334455AB7788) $display("FAIL byte_load got=%h exp=1122334455ab7788", r); else pass_cnt++;
    endtask

    task automatic test_word_misalign();
        int c; logic m; logic [N-1:0] r;
        run(1'b1, 2'b01, 64'h12, 64'hDEADBEEF, c, m, r);
        total_cnt++; if (c !== 3) $display("FAIL word_mis_lat got=%0d exp=3", c); else pass_cnt++;
        total_cnt++; if (m !== 1'b1) $display("FAIL word_mis_flag got=%b exp=1", m); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (misalign !== 1'b0) $display("FAIL mis_after_ready got=%b exp=0", misalign); else pass_cnt++;
        run(1'b0, 2'b00, 64'h10, 64'h0, c, m, r);
        total_cnt++; if (r !== 64'h1122334455AB7788) $display("FAIL word_mis_nowrite got=%h exp=1122334455ab7788", r); else pass_cnt++;
        // Aligned word store into the upper half.
        run(1'b1, 2'b01, 64'h14, 64'hCAFEF00D, c, m, r);
        total_cnt++; if (m !== 1'b0) $display("FAIL word_store_mis got=%b exp=0", m); else pass_cnt++;
        run(1'b0, 2'b00, 64'h10, 64'h0, c, m, r);
        total_cnt++; if (r !== 64'hCAFEF00D55AB7788) $display("FAIL word_store_load got=%h exp=cafef00d55ab7788", r); else pass_cnt++;
    endtask

    task automatic test_other_misalign();
        int c; logic m; logic [N-1:0] r;
        run(1'b1, 2'b11, 64'h10, 64'hFFFFFFFFFFFFFFFF, c, m, r);
        total_cnt++; if (m !== 1'b1) $display("FAIL wt11_mis got=%b exp=1", m); else pass_cnt++;
        run(1'b1, 2'b10, 64'h14, 64'hFFFFFFFFFFFFFFFF, c, m, r);
        total_cnt++; if (m !== 1'b1) $display("FAIL dw14_mis got=%b exp=1", m); else pass_cnt++;
        // Load with a misaligned word writetype: never flagged.
        run(1'b0, 2'b01, 64'h12, 64'h0, c, m, r);
        total_cnt++; if (m !== 1'b0) $display("FAIL load_nomis got=%b exp=0", m); else pass_cnt++;
        total_cnt++; if (r !== 64'hCAFEF00D55AB7788) $display("FAIL mis_nowrite got=%h exp=cafef00d55ab7788", r); else pass_cnt++;
        // Byte at adr[2:0]=7 is bits [39:32].
        run(1'b1, 2'b00, 64'h17, 64'h5A, c, m, r);
        run(1'b0, 2'b00, 64'h14, 64'h0, c, m, r);
        total_cnt++; if (r !== 64'h55AB7788CAFEF05A) $display("FAIL byte17_load got=%h exp=55ab7788cafef05a", r); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [11:0] mask;
        logic [N-1:0] r;
        mask = '0;
        @(negedge clk);
        req = 1'b1; we = 1'b0; writetype = 2'b00; adr = 64'h10; writedata = '0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            mask[k] = ready;
            if (k == 7) begin
                r = readdata;
                req = 1'b0;
            end
        end
        $display("txn back_to_back ready_mask=%b rd=%h", mask, r);
        total_cnt++; if (mask !== 12'b0000_1000_1000) $display("FAIL b2b_mask got=%b exp=000010001000", mask); else pass_cnt++;
        total_cnt++; if (r !== 64'hCAFEF05A55AB7788) $display("FAIL b2b_rd got=%h exp=cafef05a55ab7788", r); else pass_cnt++;
    endtask

    task automatic test_reset_busy();
        int c; logic m; logic [N-1:0] r;
        int seen;
        run(1'b1, 2'b10, 64'h20, 64'h0123456789ABCDEF, c, m, r);
        @(negedge clk);
        req = 1'b1; we = 1'b1; writetype = 2'b10; adr = 64'h20; writedata = 64'hFFFFFFFFFFFFFFFF;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);          // first BUSY cycle
        @(negedge clk);          // last BUSY cycle: reset on the commit edge
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (ready) seen++;
        end
        $display("txn reset_in_busy ready_seen=%0d rd=%h", seen, readdata);
        total_cnt++; if (seen !== 0) $display("FAIL rst_busy_ready got=%0d exp=0", seen); else pass_cnt++;
        total_cnt++; if (readdata !== 64'h0) $display("FAIL rst_busy_rd got=%h exp=0", readdata); else pass_cnt++;
        run(1'b0, 2'b00, 64'h20, 64'h0, c, m, r);
        total_cnt++; if (r !== 64'h0123456789ABCDEF) $display("FAIL rst_busy_nowrite got=%h exp=0123456789abcdef", r); else pass_cnt++;
        // Reset together with req: nothing is accepted.
        @(negedge clk);
        reset = 1'b1; req = 1'b1; we = 1'b0; adr = 64'h10;
        @(negedge clk);
        reset = 1'b0; req = 1'b0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (ready) seen++;
        end
        $display("txn reset_with_req ready_seen=%0d", seen);
        total_cnt++; if (seen !== 0) $display("FAIL rst_req_ready got=%0d exp=0", seen); else pass_cnt++;
    endtask

    task automatic test_wrap();
        int c; logic m; logic [N-1:0] r;
        run(1'b0, 2'b00, 64'h10 + 64'(DEPTH * 8), 64'h0, c, m, r);
        total_cnt++; if (r !== 64'hCAFEF05A55AB7788) $display("FAIL wrap_load got=%h exp=cafef05a55ab7788", r); else pass_cnt++;
        total_cnt++; if (c !== 3) $display("FAIL wrap_lat got=%0d exp=3", c); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_dword();
        test_byte();
        test_word_misalign();
        test_other_misalign();
        test_back_to_back();
        test_reset_busy();
        test_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
